// File: rtl/lock_ctrl_if.sv
// Button, switch and status bundle between the board I/O and the lock controller.
interface lock_ctrl_if;
    logic       btn_enter;
    logic       btn_oops;
    logic       btn_clear;
    logic       btn_prog;
    logic [3:0] login;
    logic [3:0] state_flag;
    logic [1:0] tries_left;
    logic       lockout;
    logic       unlocked;

    modport master (
        output btn_enter, btn_oops, btn_clear, btn_prog, login,
        input  state_flag, tries_left, lockout, unlocked
    );

    modport slave (
        input  btn_enter, btn_oops, btn_clear, btn_prog, login,
        output state_flag, tries_left, lockout, unlocked
    );
endinterface

// File: rtl/lock_ctrl.sv
// Combination-lock front end: button conditioning (sync, debounce, one-shot),
// password check, failed-try counting, timed lockout and password programming.
module lock_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MAX_TRIES       = 3,
    parameter int unsigned LOCKOUT_CYCLES  = 500000000,
    parameter logic [3:0]  DEFAULT_PASSW   = 4'b1001
) (
    input  logic       clk,
    input  logic       reset_n,
    lock_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]       MAX_T    = 2'(MAX_TRIES);

    // Button bit positions inside the conditioning vectors.
    localparam int unsigned B_ENTER = 0;
    localparam int unsigned B_OOPS  = 1;
    localparam int unsigned B_CLEAR = 2;
    localparam int unsigned B_PROG  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERROR,
        ST_LOCKOUT,
        ST_OPEN,
        ST_PROG
    } state_t;

    logic [3:0] btn_raw;

    logic [3:0] btn_s1_q, btn_s1_d;
    logic [3:0] btn_s2_q, btn_s2_d;
    logic [3:0] login_s1_q, login_s1_d;
    logic [3:0] login_s2_q, login_s2_d;
    logic [3:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [3:0] db_lvl_q, db_lvl_d;
    logic [3:0] db_prev_q, db_prev_d;
    logic [3:0] press_q, press_d;

    state_t     state_q, state_d;
    logic [3:0] passw_q, passw_d;
    logic [1:0] tries_q, tries_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic       enter_p, oops_p, clear_p, prog_p;
    logic [1:0] tries_dec;
    logic [3:0] flag;

    assign btn_raw = {bus.btn_prog, bus.btn_clear, bus.btn_oops, bus.btn_enter};

    assign enter_p = press_q[B_ENTER];
    assign oops_p  = press_q[B_OOPS];
    assign clear_p = press_q[B_CLEAR];
    assign prog_p  = press_q[B_PROG];

    // Synchronize inputs, debounce each button and form one-cycle press pulses.
    always_comb begin
        btn_s1_d   = btn_raw;
        btn_s2_d   = btn_s1_q;
        login_s1_d = bus.login;
        login_s2_d = login_s1_q;
        db_prev_d  = db_lvl_q;
        press_d    = db_lvl_q & ~db_prev_q;
        db_lvl_d   = db_lvl_q;
        db_cnt_d   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (btn_s2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == CNT_MAX) begin
                    db_lvl_d[i] = ~db_lvl_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Conditioning registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            login_s1_q <= '0;
            login_s2_q <= '0;
            db_cnt_q   <= '0;
            db_lvl_q   <= '0;
            db_prev_q  <= '0;
            press_q    <= '0;
        end else begin
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            login_s1_q <= login_s1_d;
            login_s2_q <= login_s2_d;
            db_cnt_q   <= db_cnt_d;
            db_lvl_q   <= db_lvl_d;
            db_prev_q  <= db_prev_d;
            press_q    <= press_d;
        end
    end

    // Next state, password, try counter and lockout timer.
    always_comb begin
        state_d   = state_q;
        passw_d   = passw_q;
        tries_d   = tries_q;
        tmr_d     = tmr_q;
        tries_dec = (tries_q != '0) ? tries_q - 2'd1 : '0;
        case (state_q)
            ST_IDLE: begin
                if (enter_p) begin
                    if (login_s2_q == passw_q) begin
                        state_d = ST_OPEN;
                        tries_d = MAX_T;
                    end else begin
                        tries_d = tries_dec;
                        if (tries_dec == '0) begin
                            state_d = ST_LOCKOUT;
                            tmr_d   = TMR_LOAD;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end
                end
            end
            ST_ERROR: begin
                if (oops_p) state_d = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                    tries_d = MAX_T;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_OPEN: begin
                if (clear_p)     state_d = ST_IDLE;
                else if (prog_p) state_d = ST_PROG;
            end
            ST_PROG: begin
                if (clear_p) begin
                    state_d = ST_OPEN;
                end else if (enter_p) begin
                    passw_d = login_s2_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            passw_q <= DEFAULT_PASSW;
            tries_q <= MAX_T;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            passw_q <= passw_d;
            tries_q <= tries_d;
            tmr_q   <= tmr_d;
        end
    end

    // LED flag pattern decoded from the state register.
    always_comb begin
        flag = 4'b0001;
        case (state_q)
            ST_IDLE:    flag = 4'b0001;
            ST_ERROR:   flag = 4'b0010;
            ST_LOCKOUT: flag = 4'b0110;
            ST_OPEN:    flag = 4'b1000;
            ST_PROG:    flag = 4'b1001;
            default:    flag = 4'b0001;
        endcase
    end

    assign bus.state_flag = flag;
    assign bus.tries_left = tries_q;
    assign bus.lockout    = (state_q == ST_LOCKOUT);
    assign bus.unlocked   = (state_q == ST_OPEN) || (state_q == ST_PROG);

endmodule

// File: tb/tb_lock_ctrl.sv
// Self-checking bench for lock_ctrl: directed vector table, hand-written
// timing sequences, and random button traffic against an event-level model.
module tb_lock_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned LK = 20;
    localparam int unsigned MT = 3;

    localparam logic [3:0] B_EN = 4'b0001;
    localparam logic [3:0] B_OO = 4'b0010;
    localparam logic [3:0] B_CL = 4'b0100;
    localparam logic [3:0] B_PR = 4'b1000;

    logic clk = 1'b0;
    logic reset_n;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lock_ctrl_if bus();

    lock_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .MAX_TRIES      (MT),
        .LOCKOUT_CYCLES (LK),
        .DEFAULT_PASSW  (4'b1001)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0] btns;
        logic [3:0] lg;
        logic [3:0] flag;
        logic [1:0] tries;
        logic       lk;
        logic       ul;
    } vec_t;

    vec_t vecs[$];

    // Event-level reference model: one step per press event.
    typedef enum {M_IDLE, M_ERR, M_LOCK, M_OPEN, M_PROG} mmode_t;
    mmode_t      m_mode;
    int          m_tries;
    logic [3:0]  m_passw;
    int unsigned m_lock_end;

    task automatic check(input string name, input logic [3:0] f, input logic [1:0] t,
                         input logic lk, input logic ul);
        checks++;
        if (bus.state_flag !== f || bus.tries_left !== t || bus.lockout !== lk || bus.unlocked !== ul) begin
            errors++;
            $display("FAIL %s: got flag=%b tries=%0d lockout=%b unlocked=%b, want flag=%b tries=%0d lockout=%b unlocked=%b",
                     name, bus.state_flag, bus.tries_left, bus.lockout, bus.unlocked, f, t, lk, ul);
        end
    endtask

    task automatic set_btns(input logic [3:0] b);
        bus.btn_enter = b[0];
        bus.btn_oops  = b[1];
        bus.btn_clear = b[2];
        bus.btn_prog  = b[3];
    endtask

    // Hold buttons 6 cycles, release, let debouncers settle; t_ev is the
    // cycle count after the edge where the FSM acts on the press.
    task automatic press(input logic [3:0] b, input logic [3:0] lg, output int unsigned t_ev);
        @(negedge clk);
        bus.login = lg;
        t_ev = cyc + 8;
        set_btns(b);
        repeat (6) @(negedge clk);
        set_btns('0);
        repeat (10) @(negedge clk);
    endtask

    task automatic add(input logic [3:0] b, input logic [3:0] lg, input logic [3:0] f,
                       input logic [1:0] t, input logic lk, input logic ul);
        vec_t v;
        v.btns = b; v.lg = lg; v.flag = f; v.tries = t; v.lk = lk; v.ul = ul;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        set_btns('0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [3:0] m_flag();
        case (m_mode)
            M_IDLE:  return 4'b0001;
            M_ERR:   return 4'b0010;
            M_LOCK:  return 4'b0110;
            M_OPEN:  return 4'b1000;
            M_PROG:  return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic m_apply(input logic [3:0] b, input logic [3:0] lg, input int unsigned t);
        if (m_mode == M_LOCK) begin
            if (t <= m_lock_end) return;
            m_mode  = M_IDLE;
            m_tries = MT;
        end
        case (m_mode)
            M_IDLE: if (b[0]) begin
                if (lg == m_passw) begin
                    m_mode  = M_OPEN;
                    m_tries = MT;
                end else begin
                    m_tries = (m_tries > 0) ? m_tries - 1 : 0;
                    if (m_tries == 0) begin
                        m_mode     = M_LOCK;
                        m_lock_end = t + LK;
                    end else begin
                        m_mode = M_ERR;
                    end
                end
            end
            M_ERR:  if (b[1]) m_mode = M_IDLE;
            M_OPEN: if (b[2]) m_mode = M_IDLE; else if (b[3]) m_mode = M_PROG;
            M_PROG: if (b[2]) m_mode = M_OPEN;
                    else if (b[0]) begin m_passw = lg; m_mode = M_IDLE; end
            default: ;
        endcase
    endtask

    task automatic m_expire();
        if (m_mode == M_LOCK && cyc >= m_lock_end) begin
            m_mode  = M_IDLE;
            m_tries = MT;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0;
        int unsigned tev;
        logic [3:0] b;
        logic [3:0] lg;

        reset_n = 1'b0;
        bus.login = 4'b0000;
        set_btns('0);
        repeat (3) @(negedge clk);
        check("reset", 4'b0001, 2'd3, 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Short enter glitch with the right code must not open the lock.
        @(negedge clk);
        bus.login = 4'b1001;
        set_btns(B_EN);
        repeat (3) @(negedge clk);
        set_btns('0);
        repeat (12) @(negedge clk);
        check("glitch", 4'b0001, 2'd3, 1'b0, 1'b0);

        // Held enter: state changes on edge 7 after the press, not before.
        @(negedge clk);
        set_btns(B_EN);
        repeat (7) @(negedge clk);
        check("edge6", 4'b0001, 2'd3, 1'b0, 1'b0);
        @(negedge clk);
        check("edge7", 4'b1000, 2'd3, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        set_btns('0);
        repeat (10) @(negedge clk);

        // Directed vectors, starting from OPEN with passw 1001.
        add(B_CL,           4'b0000, 4'b0001, 2'd3, 1'b0, 1'b0);
        add(B_EN,           4'b0000, 4'b0010, 2'd2, 1'b0, 1'b0);
        add(B_CL | B_PR,    4'b0000, 4'b0010, 2'd2, 1'b0, 1'b0);
        add(B_EN,           4'b1001, 4'b0010, 2'd2, 1'b0, 1'b0);
        add(B_OO,           4'b0000, 4'b0001, 2'd2, 1'b0, 1'b0);
        add(B_EN,           4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0);
        add(B_OO,           4'b0000, 4'b0001, 2'd1, 1'b0, 1'b0);
        add(B_EN,           4'b1001, 4'b1000, 2'd3, 1'b0, 1'b1);
        add(B_EN | B_OO,    4'b1001, 4'b1000, 2'd3, 1'b0, 1'b1);
        add(B_PR,           4'b1001, 4'b1001, 2'd3, 1'b0, 1'b1);
        add(B_EN,           4'b0110, 4'b0001, 2'd3, 1'b0, 1'b0);
        add(B_EN,           4'b1001, 4'b0010, 2'd2, 1'b0, 1'b0);
        add(B_OO,           4'b0000, 4'b0001, 2'd2, 1'b0, 1'b0);
        add(B_EN,           4'b0110, 4'b1000, 2'd3, 1'b0, 1'b1);
        add(B_PR,           4'b0110, 4'b1001, 2'd3, 1'b0, 1'b1);
        add(B_CL | B_EN,    4'b1111, 4'b1000, 2'd3, 1'b0, 1'b1);
        add(B_CL,           4'b0000, 4'b0001, 2'd3, 1'b0, 1'b0);
        add(B_EN,           4'b1111, 4'b0010, 2'd2, 1'b0, 1'b0);
        add(B_OO,           4'b0000, 4'b0001, 2'd2, 1'b0, 1'b0);
        add(B_EN,           4'b0110, 4'b1000, 2'd3, 1'b0, 1'b1);
        add(B_PR|B_EN|B_OO, 4'b0110, 4'b1001, 2'd3, 1'b0, 1'b1);
        add(B_EN,           4'b0011, 4'b0001, 2'd3, 1'b0, 1'b0);
        add(B_OO | B_EN,    4'b0011, 4'b1000, 2'd3, 1'b0, 1'b1);
        add(B_CL|B_PR|B_EN, 4'b0011, 4'b0001, 2'd3, 1'b0, 1'b0);
        add(B_EN,           4'b0000, 4'b0010, 2'd2, 1'b0, 1'b0);
        add(B_OO,           4'b0000, 4'b0001, 2'd2, 1'b0, 1'b0);
        add(B_EN,           4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0);
        add(B_OO,           4'b0000, 4'b0001, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            press(vecs[i].btns, vecs[i].lg, tev);
            check($sformatf("vec%0d", i), vecs[i].flag, vecs[i].tries, vecs[i].lk, vecs[i].ul);
        end

        // Third miss: lockout, buttons ignored, exact 20-cycle dwell.
        @(negedge clk);
        t0 = cyc;
        bus.login = 4'b0000;
        set_btns(B_EN);
        repeat (6) @(negedge clk);
        set_btns('0);
        repeat (2) @(negedge clk);
        check("lockout_entry", 4'b0110, 2'd0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        set_btns(B_EN | B_OO | B_CL);
        repeat (6) @(negedge clk);
        set_btns('0);
        while (cyc < t0 + 27) @(negedge clk);
        check("lockout_dwell19", 4'b0110, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("lockout_exit", 4'b0001, 2'd3, 1'b0, 1'b0);
        repeat (10) @(negedge clk);

        // Reset in the middle of a lockout restores defaults (passw back to 1001).
        press(B_EN, 4'b0000, tev);
        press(B_OO, 4'b0000, tev);
        press(B_EN, 4'b0000, tev);
        press(B_OO, 4'b0000, tev);
        press(B_EN, 4'b0000, tev);
        check("lockout_again", 4'b0110, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset_mid_lockout", 4'b0001, 2'd3, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        press(B_EN, 4'b0011, tev);
        check("old_passw_gone", 4'b0010, 2'd2, 1'b0, 1'b0);
        press(B_OO, 4'b0000, tev);
        press(B_EN, 4'b1001, tev);
        check("default_passw", 4'b1000, 2'd3, 1'b0, 1'b1);

        // Reset while a press pulse is pending must swallow it.
        press(B_CL, 4'b0000, tev);
        @(negedge clk);
        bus.login = 4'b1001;
        set_btns(B_EN);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        set_btns('0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("reset_mid_debounce", 4'b0001, 2'd3, 1'b0, 1'b0);

        // Random traffic against the event-level model.
        do_reset();
        m_mode  = M_IDLE;
        m_tries = MT;
        m_passw = 4'b1001;
        m_lock_end = 0;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 25)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) b = 4'b0001 << $urandom_range(0, 3);
            else b = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) lg = m_passw;
            else lg = 4'($urandom);
            press(b, lg, tev);
            m_apply(b, lg, tev);
            m_expire();
            check($sformatf("rand%0d", i), m_flag(), 2'(m_tries), m_mode == M_LOCK,
                  m_mode == M_OPEN || m_mode == M_PROG);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_ctrl.md
Name: lock_ctrl

Overview:
Front-end controller that sequences the 4-bit switch combination lock on the Arty board. It conditions the raw push buttons with a synchronizer, a debouncer and a one-shot, and validates login attempts against a stored password. It counts failed tries, enforces a timed lockout, and allows the password to be reprogrammed while the lock is open. Its `state_flag` outputs drive the existing `led_dimmer` instances one-for-one.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed before a button level is accepted (10 ms at 100 MHz); must be at least 2.
- MAX_TRIES, 3, wrong entries allowed before lockout; legal range 1..3.
- LOCKOUT_CYCLES, 500000000, lockout duration in clk cycles (5 s); must be at least 1.
- DEFAULT_PASSW, 4'b1001, password loaded at reset.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- btn_enter  in  1  raw button: submit the combination.
- btn_oops  in  1  raw button: acknowledge an error.
- btn_clear  in  1  raw button: relock, or cancel programming.
- btn_prog  in  1  raw button: enter programming mode (only while OPEN).
- login  in  4  switch combination; synchronized internally with 2 flops.
- state_flag  out  4  LED flag pattern per state.
- tries_left  out  2  remaining attempts.
- lockout  out  1  high while in LOCKOUT.
- unlocked  out  1  high while in OPEN or PROG.

Behaviour:
- Reset (reset_n low, asynchronous) sets the following, and reset wins over everything, including mid-debounce and mid-lockout:
  - state = IDLE, passw = DEFAULT_PASSW, tries_left = MAX_TRIES.
  - Lockout timer = 0, debounce counters = 0, debounced levels = 0.
  - state_flag = 4'b0001, lockout = 0, unlocked = 0.
- Button conditioning, applied independently to each button:
  - 2-flop synchronizer, then a debounce counter.
  - The counter clears whenever the synced level equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles and the counter clears.
  - A press pulse `*_p` is the debounced level high and its previous-cycle copy low; it is exactly 1 cycle wide.
  - Latency: with a pin held high from edge 0, the FSM state changes on edge DEBOUNCE_CYCLES+3. Glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse. Release produces no pulse.
- `login` is compared using its synced value in the cycle the enter_p pulse is high.
- FSM (registered; all outputs decoded from the state register):
  - IDLE, flag 0001:
    - enter_p with a match: go to OPEN, tries_left = MAX_TRIES.
    - enter_p with a mismatch: tries_left decrements. If the result is 0, go to LOCKOUT; otherwise go to ERROR.
  - ERROR, flag 0010: oops_p returns to IDLE, tries_left unchanged. All other buttons are ignored.
  - LOCKOUT, flag 0110:
    - The timer loads LOCKOUT_CYCLES-1 on entry and decrements each cycle.
    - In the cycle the timer = 0, go to IDLE and set tries_left = MAX_TRIES. Dwell is exactly LOCKOUT_CYCLES cycles.
    - All buttons are ignored.
  - OPEN, flag 1000: clear_p goes to IDLE. Otherwise prog_p goes to PROG. enter_p and oops_p are ignored.
  - PROG, flag 1001: clear_p returns to OPEN with passw unchanged. Otherwise enter_p sets passw = synced login and goes to IDLE (relocked).
- Simultaneous pulses in one cycle resolve with priority clear > prog > enter > oops; only one transition per cycle.
- tries_left never underflows and saturates at MAX_TRIES.
- The new passw takes effect from the next cycle.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=20, MAX_TRIES=3.
1. Reset, login=1001, hold btn_enter 10 cycles -> state_flag 0001→1000 on edge 7 after the press, unlocked=1, tries_left=3; a 3-cycle enter glitch beforehand causes no change.
2. login=0000, press enter -> flag 0010, tries_left=2; press oops -> 0001; repeat twice -> third miss gives flag 0110, lockout=1, tries_left=0.
3. In LOCKOUT press enter/oops/clear -> no change; exactly 20 cycles after entry -> flag 0001, tries_left=3, lockout=0.
4. OPEN, press prog -> 1001; login=0110, enter -> 0001; login=1001, enter -> 0010 (miss); login=0110, enter -> 1000.
5. In PROG, press clear and enter simultaneously -> OPEN, passw unchanged; assert reset_n=0 mid-lockout -> immediate flag 0001, passw=1001, tries_left=3.
